// File: rtl/mac_pkg.sv
// Constants shared across the MAC datapath: default operand width and the
// multiplier handshake state encoding.
package mac_pkg;

  localparam int unsigned MacWidth = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mac_multiplier.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock, acting
// as the responder on the 4-phase start_mul/valid_mul handshake.
module mac_multiplier
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MacWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ldA,
  input  logic                 ldB,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 start_mul,
  output logic                 valid_mul,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]       upper;
  logic [2*WIDTH-1:0]   p_step;

  // Carry of the W-bit add lands in upper[WIDTH] and shifts into the top of P.
  assign upper  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign p_step = {upper, p_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    p_d       = p_q;
    product_d = product_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (ldA) a_d = a_in;
        if (ldB) b_d = b_in;
        if (start_mul) begin
          p_d     = {{WIDTH{1'b0}}, b_q};
          m_d     = a_q;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d = p_step;
        if (cnt_q == CntLast) begin
          product_d = p_step;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (ldA) a_d = a_in;
        if (ldB) b_d = b_in;
        if (!start_mul) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        m_d       = '0;
        p_d       = '0;
        product_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      p_q       <= p_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_mul = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign product   = product_q;

endmodule

// File: tb/tb_mac_multiplier.sv
// Directed self-checking bench for mac_multiplier: a vector table of products
// plus hand-written sequences for handshake and reset corner cases.
module tb_mac_multiplier;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           ldA, ldB;
  logic [W-1:0]   a_in, b_in;
  logic           start_mul;
  logic           valid_mul, busy;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  mac_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ldA       (ldA),
    .ldB       (ldB),
    .a_in      (a_in),
    .b_in      (b_in),
    .start_mul (start_mul),
    .valid_mul (valid_mul),
    .busy      (busy),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in = a; b_in = b; ldA = 1'b1; ldB = 1'b1;
    step();
    ldA = 1'b0; ldB = 1'b0;
  endtask

  // Counts edges after the start edge until valid_mul; bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid_mul && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  // Assumes IDLE with operands loaded; runs a full held-start handshake.
  task automatic run_op(input string name, input logic [2*W-1:0] exp, input int hold);
    int cyc;
    start_mul = 1'b1;
    step();
    check({name, " busy"}, {31'd0, busy}, 32'd1);
    wait_valid(cyc);
    check({name, " latency"}, cyc, W);
    check({name, " product"}, {16'd0, product}, {16'd0, exp});
    for (int i = 0; i < hold; i++) begin
      step();
      check({name, " hold valid"}, {31'd0, valid_mul}, 32'd1);
      check({name, " hold product"}, {16'd0, product}, {16'd0, exp});
    end
    start_mul = 1'b0;
    step();
    check({name, " release valid"}, {31'd0, valid_mul}, 32'd0);
    check({name, " kept product"}, {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    int cyc;
    vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
    vecs[3] = '{a: 8'd1,   b: 8'd255, exp: 16'd255};
    vecs[4] = '{a: 8'd2,   b: 8'd128, exp: 16'd256};
    vecs[5] = '{a: 8'd170, b: 8'd85,  exp: 16'd14450};
    vecs[6] = '{a: 8'd200, b: 8'd0,   exp: 16'd0};

    // Reset with random inputs and ldA high
    rst = 1'b1; ldA = 1'b1; ldB = 1'b0; start_mul = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);
    step();
    a_in = W'($urandom); b_in = W'($urandom);
    step();
    rst = 1'b0; ldA = 1'b0;
    check("reset valid", {31'd0, valid_mul}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset product", {16'd0, product}, 32'd0);
    // A must still be 0: only B is loaded, so the product is 0.
    b_in = 8'd5; ldB = 1'b1;
    step();
    ldB = 1'b0;
    run_op("reset A zero", 16'd0, 0);

    // Basic op with start held five extra cycles
    load(8'd13, 8'd11);
    run_op("basic 13x11", 16'd143, 5);

    foreach (vecs[i]) begin
      load(vecs[i].a, vecs[i].b);
      run_op($sformatf("vec%0d", i), vecs[i].exp, 0);
    end

    // Operand protection: ldA during RUN is ignored
    load(8'd7, 8'd9);
    start_mul = 1'b1;
    step();
    step();
    step();
    a_in = 8'd100; ldA = 1'b1;
    step();
    ldA = 1'b0;
    wait_valid(cyc);
    check("protect product", {16'd0, product}, 32'd63);
    start_mul = 1'b0;
    step();
    a_in = 8'd100; ldA = 1'b1;
    step();
    ldA = 1'b0;
    run_op("protect 100x9", 16'd900, 0);

    // Early release: single-cycle start
    load(8'd6, 8'd6);
    start_mul = 1'b1;
    step();
    start_mul = 1'b0;
    check("early busy", {31'd0, busy}, 32'd1);
    wait_valid(cyc);
    check("early latency", cyc, W);
    check("early product", {16'd0, product}, 32'd36);
    step();
    check("early valid drop", {31'd0, valid_mul}, 32'd0);
    check("early idle busy", {31'd0, busy}, 32'd0);
    check("early product kept", {16'd0, product}, 32'd36);

    // Reset mid-RUN after iteration 4
    load(8'd200, 8'd200);
    start_mul = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("midrun busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; start_mul = 1'b0;
    check("midrun rst valid", {31'd0, valid_mul}, 32'd0);
    check("midrun rst busy", {31'd0, busy}, 32'd0);
    check("midrun rst product", {16'd0, product}, 32'd0);
    step();
    check("midrun still idle", {31'd0, busy}, 32'd0);
    load(8'd3, 8'd5);
    run_op("post reset 3x5", 16'd15, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
